// File: rtl/router_out_drain.sv
// Read-side controller for one router output port: pulls a packet from the port
// FIFO and re-emits it byte-by-byte on a valid/ready stream with sop/eop framing.
module router_out_drain #(
  parameter logic [1:0] PORT_ID   = 2'b00,
  parameter int         PKT_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 vld_out,
  input  logic                 soft_reset,
  input  logic [7:0]           fifo_data,
  output logic                 read_enb,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic                 pkt_abort,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic                 busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  logic [1:0] state;
  logic       first;
  logic [6:0] remaining;
  logic [7:0] acc;
  logic       fifo_ok, kill, accept;

  assign fifo_ok = vld_out & ~soft_reset;
  assign kill    = soft_reset & (state != IDLE);
  assign accept  = (state == SEND) & m_valid & m_ready;

  always_comb begin
    read_enb = 1'b0;
    case (state)
      IDLE:    read_enb = fifo_ok;
      SEND:    read_enb = m_ready & (remaining != 7'd0) & fifo_ok;
      WAIT:    read_enb = fifo_ok;
      default: read_enb = 1'b0;
    endcase
    // keep the FIFO untouched while the block is held in reset
    if (!resetn) read_enb = 1'b0;
  end

  assign busy       = (state != IDLE);
  assign pkt_abort  = kill;
  assign addr_err   = (state == CAPTURE) & first & (fifo_data[1:0] != PORT_ID) & ~soft_reset;
  assign pkt_done   = accept & (remaining == 7'd0) & ~soft_reset;
  assign parity_err = pkt_done & (acc != 8'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      first     <= 1'b0;
      remaining <= 7'd0;
      acc       <= 8'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_sop     <= 1'b0;
      m_eop     <= 1'b0;
      pkt_count <= '0;
    end else if (kill) begin
      // abort drops the held byte whether or not it was accepted
      state   <= IDLE;
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_enb) begin
            state <= CAPTURE;
            first <= 1'b1;
          end
        end
        CAPTURE: begin
          m_data  <= fifo_data;
          m_valid <= 1'b1;
          state   <= SEND;
          first   <= 1'b0;
          if (first) begin
            remaining <= {1'b0, fifo_data[7:2]} + 7'd1;
            acc       <= fifo_data;
            m_sop     <= 1'b1;
            m_eop     <= 1'b0;
          end else begin
            remaining <= remaining - 7'd1;
            acc       <= acc ^ fifo_data;
            m_sop     <= 1'b0;
            m_eop     <= (remaining == 7'd1);
          end
        end
        SEND: begin
          if (accept) begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            if (remaining != 7'd0) begin
              state <= read_enb ? CAPTURE : WAIT;
            end else begin
              state <= IDLE;
              if (acc == 8'd0) pkt_count <= pkt_count + {{(PKT_CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        WAIT: begin
          if (read_enb) state <= CAPTURE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_drain.sv
// Directed bench for router_out_drain: FIFO model feeds packets, a negedge
// monitor records accepted bytes and pulses, tasks check against hand values.
module tb_router_out_drain;

  logic        clock = 1'b0;
  logic        resetn, soft_reset, m_ready;
  logic        vld_out, read_enb, m_valid, m_sop, m_eop;
  logic        pkt_done, parity_err, addr_err, pkt_abort, busy;
  logic [7:0]  fifo_data = 8'd0;
  logic [7:0]  m_data;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_out_drain #(.PORT_ID(2'b01), .PKT_CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
    .fifo_data(fifo_data), .read_enb(read_enb), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop), .pkt_done(pkt_done),
    .parity_err(parity_err), .addr_err(addr_err), .pkt_abort(pkt_abort),
    .pkt_count(pkt_count), .busy(busy)
  );

  // FIFO model: data appears the cycle after read_enb
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       flush  = 1'b0;

  assign vld_out = (wr_ptr != rd_ptr);

  always @(posedge clock) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (read_enb) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // monitor
  int         cyc = 0, n_out = 0, n_done = 0, n_perr = 0, n_both = 0;
  int         n_addr = 0, n_abort = 0, addr_cyc = 0;
  logic [7:0] o_data [0:255];
  logic       o_sop  [0:255];
  logic       o_eop  [0:255];
  int         o_cyc  [0:255];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (resetn) begin
      if (m_valid && m_ready) begin
        o_data[n_out[7:0]] = m_data;
        o_sop[n_out[7:0]]  = m_sop;
        o_eop[n_out[7:0]]  = m_eop;
        o_cyc[n_out[7:0]]  = cyc;
        n_out = n_out + 1;
      end
      if (pkt_done) n_done = n_done + 1;
      if (parity_err) n_perr = n_perr + 1;
      if (pkt_done && parity_err) n_both = n_both + 1;
      if (addr_err) begin n_addr = n_addr + 1; addr_cyc = cyc; end
      if (pkt_abort) n_abort = n_abort + 1;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int k = 0; k < 200 && n_done < target; k++) tick();
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL %s timeout: pkt_done count %0d required %0d", name, n_done, target);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; soft_reset = 1'b0; m_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid, m_sop, m_eop, read_enb, busy, pkt_done, parity_err, addr_err, pkt_abort} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0", {m_valid, m_sop, m_eop, read_enb, busy, pkt_done, parity_err, addr_err, pkt_abort});
    end
    checks++;
    if (m_data !== 8'd0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_data m_data %h pkt_count %0d required 0 0", m_data, pkt_count);
    end
    resetn = 1'b1;
    tick();
  endtask

  // sends one 5-byte packet with m_ready high and checks bytes, framing, timing
  task automatic send_check(input logic [7:0] p4, input logic [15:0] exp_cnt,
                            input int exp_perr, input string name);
    logic [7:0] exp [0:4];
    int b, pc, d0, pe0, bo0, a0;
    exp[0] = 8'h0D; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33; exp[4] = p4;
    b = n_out; d0 = n_done; pe0 = n_perr; bo0 = n_both; a0 = n_addr;
    m_ready = 1'b1;
    pc = cyc + 1;
    for (int i = 0; i < 5; i++) push(exp[i]);
    wait_done(d0 + 1, name);
    tick();
    checks++;
    if (n_out - b !== 5) begin
      errors++; $display("FAIL %s byte_count got %0d required 5", name, n_out - b);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_data[b+i] !== exp[i] || o_sop[b+i] !== (i == 0) || o_eop[b+i] !== (i == 4)) begin
        errors++;
        $display("FAIL %s byte%0d got %h sop %b eop %b required %h sop %b eop %b", name, i,
                 o_data[b+i], o_sop[b+i], o_eop[b+i], exp[i], i == 0, i == 4);
      end
      checks++;
      if (o_cyc[b+i] !== pc + 2 + 2*i) begin
        errors++;
        $display("FAIL %s timing%0d got cycle %0d required %0d", name, i, o_cyc[b+i], pc + 2 + 2*i);
      end
    end
    checks++;
    if (pkt_count !== exp_cnt) begin
      errors++; $display("FAIL %s pkt_count got %0d required %0d", name, pkt_count, exp_cnt);
    end
    checks++;
    if (n_perr - pe0 !== exp_perr || n_both - bo0 !== exp_perr) begin
      errors++;
      $display("FAIL %s parity_err got %0d coincident %0d required %0d", name, n_perr - pe0, n_both - bo0, exp_perr);
    end
    checks++;
    if (n_addr !== a0) begin
      errors++; $display("FAIL %s addr_err got %0d required 0", name, n_addr - a0);
    end
  endtask

  task automatic test_basic();
    send_check(8'h0D, 16'd1, 0, "basic");
  endtask

  task automatic test_parity_err();
    send_check(8'h0C, 16'd1, 1, "parity");
  endtask

  task automatic test_len0_addr();
    int b, d0, a0, pe0;
    b = n_out; d0 = n_done; a0 = n_addr; pe0 = n_perr;
    m_ready = 1'b1;
    push(8'h02); push(8'h02);
    wait_done(d0 + 1, "len0");
    tick();
    checks++;
    if (n_out - b !== 2) begin
      errors++; $display("FAIL len0 byte_count got %0d required 2", n_out - b);
    end
    checks++;
    if (o_data[b] !== 8'h02 || o_sop[b] !== 1'b1 || o_eop[b] !== 1'b0) begin
      errors++; $display("FAIL len0 header got %h sop %b eop %b required 02 1 0", o_data[b], o_sop[b], o_eop[b]);
    end
    checks++;
    if (o_data[b+1] !== 8'h02 || o_sop[b+1] !== 1'b0 || o_eop[b+1] !== 1'b1) begin
      errors++; $display("FAIL len0 parity got %h sop %b eop %b required 02 0 1", o_data[b+1], o_sop[b+1], o_eop[b+1]);
    end
    checks++;
    if (n_addr - a0 !== 1 || addr_cyc !== o_cyc[b] - 1) begin
      errors++;
      $display("FAIL len0 addr_err count %0d at cycle %0d required 1 at %0d", n_addr - a0, addr_cyc, o_cyc[b] - 1);
    end
    checks++;
    if (n_perr !== pe0 || pkt_count !== 16'd2) begin
      errors++; $display("FAIL len0 parity_err %0d pkt_count %0d required 0 2", n_perr - pe0, pkt_count);
    end
  endtask

  task automatic test_wait();
    logic [7:0] exp [0:4];
    int b, d0, k;
    exp[0] = 8'h0D; exp[1] = 8'h11; exp[2] = 8'h22; exp[3] = 8'h33; exp[4] = 8'h0D;
    b = n_out; d0 = n_done;
    m_ready = 1'b1;
    push(exp[0]); push(exp[1]); push(exp[2]);
    for (k = 0; k < 50 && n_out - b < 3; k++) tick();
    repeat (10) tick();
    @(negedge clock);
    checks++;
    if (n_out - b !== 3 || m_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_state bytes %0d m_valid %b busy %b required 3 0 1", n_out - b, m_valid, busy);
    end
    tick();
    push(exp[3]); push(exp[4]);
    wait_done(d0 + 1, "wait");
    tick();
    checks++;
    if (n_out - b !== 5) begin
      errors++; $display("FAIL wait byte_count got %0d required 5", n_out - b);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_data[b+i] !== exp[i]) begin
        errors++; $display("FAIL wait byte%0d got %h required %h", i, o_data[b+i], exp[i]);
      end
    end
    checks++;
    if (pkt_count !== 16'd3) begin
      errors++; $display("FAIL wait pkt_count got %0d required 3", pkt_count);
    end
  endtask

  task automatic test_abort();
    int d0, ab0, k;
    d0 = n_done; ab0 = n_abort;
    m_ready = 1'b0;
    push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
    for (k = 0; k < 20 && !m_valid; k++) tick();
    repeat (31) tick();
    checks++;
    if (m_valid !== 1'b1 || m_sop !== 1'b1 || m_data !== 8'h0D) begin
      errors++; $display("FAIL abort_stall m_valid %b sop %b data %h required 1 1 0d", m_valid, m_sop, m_data);
    end
    soft_reset = 1'b1; flush = 1'b1;
    @(negedge clock);
    checks++;
    if (pkt_abort !== 1'b1 || read_enb !== 1'b0) begin
      errors++; $display("FAIL abort_pulse pkt_abort %b read_enb %b required 1 0", pkt_abort, read_enb);
    end
    tick();
    soft_reset = 1'b0; flush = 1'b0;
    @(negedge clock);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || pkt_abort !== 1'b0) begin
      errors++; $display("FAIL abort_after m_valid %b busy %b pkt_abort %b required 0 0 0", m_valid, busy, pkt_abort);
    end
    checks++;
    if (n_abort - ab0 !== 1 || n_done !== d0 || pkt_count !== 16'd3) begin
      errors++;
      $display("FAIL abort_counts aborts %0d dones %0d pkt_count %0d required 1 0 3", n_abort - ab0, n_done - d0, pkt_count);
    end
    tick();
    soft_reset = 1'b1;
    @(negedge clock);
    checks++;
    if (pkt_abort !== 1'b0) begin
      errors++; $display("FAIL idle_soft_reset pkt_abort %b required 0", pkt_abort);
    end
    tick();
    soft_reset = 1'b0;
    tick();
    send_check(8'h0D, 16'd4, 0, "after_abort");
  endtask

  task automatic test_reset_mid();
    int b, k;
    b = n_out;
    m_ready = 1'b1;
    push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
    for (k = 0; k < 50 && n_out - b < 2; k++) tick();
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_sop, m_eop, read_enb, busy, pkt_done, parity_err, addr_err, pkt_abort} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_ctrl got %b required 0", {m_valid, m_sop, m_eop, read_enb, busy, pkt_done, parity_err, addr_err, pkt_abort});
    end
    checks++;
    if (m_data !== 8'd0 || pkt_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid_data m_data %h pkt_count %0d required 0 0", m_data, pkt_count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_len0_addr();
    test_wait();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
